// File: rtl/msrv_32_pkg.sv
// Shared msrv_32 definitions: control-flow opcode[6:2] values and 2-bit
// branch counter encodings.
package msrv_32_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_BRN  = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b11011;
  localparam logic [OPC_W-1:0] OPC_JALR = 5'b11001;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Unconditional jumps train straight to strong-taken.
  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/msrv_32_sat_counter.sv
// 2-bit saturating branch counter next-state logic; force_strong pins the
// counter to strong-taken regardless of outcome.
module msrv_32_sat_counter
  import msrv_32_pkg::*;
(
  input  ctr_t state,
  input  logic taken,
  input  logic force_strong,
  output ctr_t next_state
);

  always_comb begin
    next_state = state;
    if (force_strong) begin
      next_state = ST;
    end else if (taken) begin
      if (state != ST) next_state = ctr_t'(2'(state + 2'd1));
    end else begin
      if (state != SNT) next_state = ctr_t'(2'(state - 2'd1));
    end
  end

endmodule

// File: rtl/msrv_32_branch_predictor.sv
// Direct-mapped branch predictor / target buffer with registered mispredict
// redirect. Define MSRV_32_BP_STATS_EN to add update/mispredict counters.
module msrv_32_branch_predictor
  import msrv_32_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
)(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [31:0]      pc_in,
  output logic             pred_hit_out,
  output logic             pred_taken_out,
  output logic [31:0]      pred_target_out,
  input  logic             upd_valid_in,
  input  logic [31:0]      upd_pc_in,
  input  logic [OPC_W-1:0] upd_opcode_6_to_2_in,
  input  logic             upd_branch_taken_in,
  input  logic [31:0]      upd_target_in,
  input  logic             upd_pred_taken_in,
  input  logic [31:0]      upd_pred_target_in,
  output logic             mispredict_out,
  output logic [31:0]      redirect_pc_out
`ifdef MSRV_32_BP_STATS_EN
  ,
  output logic [31:0]      stat_updates_out,
  output logic [31:0]      stat_mispredicts_out
`endif
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_jump;
  logic             accept;
  logic             mis_c;
  logic [31:0]      redirect_c;
  ctr_t             ctr_next;

  // Fetch-side lookup: purely combinational from current table state.
  always_comb begin
    rd_idx          = pc_in[IDX+1:2];
    rd_tag          = pc_in[31:IDX+2];
    pred_hit_out    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken_out  = pred_hit_out && ctr_q[rd_idx][1];
    pred_target_out = pred_taken_out ? tgt_q[rd_idx] : pc_in + 32'd4;
  end

  always_comb begin
    up_idx     = upd_pc_in[IDX+1:2];
    up_tag     = upd_pc_in[31:IDX+2];
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_jump    = is_jump(upd_opcode_6_to_2_in);
    accept     = upd_valid_in && (up_jump || (upd_opcode_6_to_2_in == OPC_BRN));
    mis_c      = (upd_pred_taken_in != upd_branch_taken_in) ||
                 (upd_branch_taken_in && (upd_pred_target_in != upd_target_in));
    redirect_c = upd_branch_taken_in ? upd_target_in : upd_pc_in + 32'd4;
  end

  msrv_32_sat_counter u_sat_counter (
    .state        (ctr_q[up_idx]),
    .taken        (upd_branch_taken_in),
    .force_strong (up_jump),
    .next_state   (ctr_next)
  );

  // Table training: hits step the counter, taken misses allocate.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= WNT;
        tgt_q[i] <= '0;
      end
    end else if (accept) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
        if (upd_branch_taken_in) tgt_q[up_idx] <= upd_target_in;
      end else if (upd_branch_taken_in) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target_in;
        ctr_q[up_idx]   <= up_jump ? ST : WT;
      end
    end
  end

  // Redirect holds its last value between mispredicts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mispredict_out  <= 1'b0;
      redirect_pc_out <= '0;
    end else begin
      mispredict_out <= accept && mis_c;
      if (accept && mis_c) redirect_pc_out <= redirect_c;
    end
  end

`ifdef MSRV_32_BP_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_updates_out     <= '0;
      stat_mispredicts_out <= '0;
    end else begin
      if (accept && (stat_updates_out != '1))
        stat_updates_out <= stat_updates_out + 32'd1;
      if (accept && mis_c && (stat_mispredicts_out != '1))
        stat_mispredicts_out <= stat_mispredicts_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msrv_32_branch_predictor.sv
// Self-checking bench for msrv_32_branch_predictor: directed scenarios then
// random updates against an arithmetic table model (ENTRIES = 16).
module tb_msrv_32_branch_predictor;

  localparam int ENT = 16;
  localparam logic [4:0] BRN  = 5'b11000;
  localparam logic [4:0] JAL  = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pred_hit_out, pred_taken_out;
  logic [31:0] pred_target_out;
  logic        upd_valid_in = 1'b0;
  logic [31:0] upd_pc_in = '0;
  logic [4:0]  upd_opcode_6_to_2_in = '0;
  logic        upd_branch_taken_in = 1'b0;
  logic [31:0] upd_target_in = '0;
  logic        upd_pred_taken_in = 1'b0;
  logic [31:0] upd_pred_target_in = '0;
  logic        mispredict_out;
  logic [31:0] redirect_pc_out;
`ifdef MSRV_32_BP_STATS_EN
  logic [31:0] stat_updates_out, stat_mispredicts_out;
`endif

  always #5 clk_in = ~clk_in;

  msrv_32_branch_predictor #(.ENTRIES(ENT)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .pc_in                (pc_in),
    .pred_hit_out         (pred_hit_out),
    .pred_taken_out       (pred_taken_out),
    .pred_target_out      (pred_target_out),
    .upd_valid_in         (upd_valid_in),
    .upd_pc_in            (upd_pc_in),
    .upd_opcode_6_to_2_in (upd_opcode_6_to_2_in),
    .upd_branch_taken_in  (upd_branch_taken_in),
    .upd_target_in        (upd_target_in),
    .upd_pred_taken_in    (upd_pred_taken_in),
    .upd_pred_target_in   (upd_pred_target_in),
    .mispredict_out       (mispredict_out),
    .redirect_pc_out      (redirect_pc_out)
`ifdef MSRV_32_BP_STATS_EN
    ,
    .stat_updates_out     (stat_updates_out),
    .stat_mispredicts_out (stat_mispredicts_out)
`endif
  );

  // Reference model: table of (valid, full pc-derived tag, counter 0..3, target).
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  int          m_ctr   [ENT];
  logic [31:0] m_tgt   [ENT];
  bit          m_mis;
  logic [31:0] m_red;
  int unsigned m_nupd, m_nmis;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = '0;
    end
    m_mis = 0; m_red = '0; m_nupd = 0; m_nmis = 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output bit hit,
                                     output bit tkn, output logic [31:0] tgt);
    int i;
    i   = int'((pc / 4) % ENT);
    hit = m_valid[i] && (m_tag[i] == pc / (4 * ENT));
    tkn = hit && (m_ctr[i] >= 2);
    tgt = tkn ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic [4:0] opc,
                                       input bit t, input logic [31:0] tg,
                                       input bit pt, input logic [31:0] ptg);
    int i;
    bit hit, jmp, mis;
    m_mis = 0;
    if (!(opc == BRN || opc == JAL || opc == JALR)) return;
    jmp = (opc != BRN);
    i   = int'((pc / 4) % ENT);
    hit = m_valid[i] && (m_tag[i] == pc / (4 * ENT));
    mis = (pt != t) || (t && ptg != tg);
    m_nupd++;
    if (mis) begin
      m_mis = 1; m_nmis++;
      m_red = t ? tg : pc + 32'd4;
    end
    if (hit) begin
      if (jmp) m_ctr[i] = 3;
      else if (t) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      if (t) m_tgt[i] = tg;
    end else if (t) begin
      m_valid[i] = 1; m_tag[i] = pc / (4 * ENT); m_tgt[i] = tg;
      m_ctr[i] = jmp ? 3 : 2;
    end
  endfunction

  // Combinational lookup of pc against the model (called between edges).
  task automatic look(input string tag, input logic [31:0] pc);
    bit h, tk;
    logic [31:0] tg;
    pc_in = pc;
    #1;
    model_pred(pc, h, tk, tg);
    chk({tag, "_hit"}, 32'(pred_hit_out), 32'(h));
    chk({tag, "_taken"}, 32'(pred_taken_out), 32'(tk));
    chk({tag, "_target"}, pred_target_out, tg);
  endtask

  // One update cycle: drive at negedge, clock, then check the registered outputs.
  task automatic upd(input string tag, input logic [31:0] pc, input logic [4:0] opc,
                     input bit t, input logic [31:0] tg, input bit pt,
                     input logic [31:0] ptg);
    upd_valid_in = 1'b1; upd_pc_in = pc; upd_opcode_6_to_2_in = opc;
    upd_branch_taken_in = t; upd_target_in = tg;
    upd_pred_taken_in = pt; upd_pred_target_in = ptg;
    @(posedge clk_in);
    model_update(pc, opc, t, tg, pt, ptg);
    @(negedge clk_in);
    upd_valid_in = 1'b0;
    chk({tag, "_mispredict"}, 32'(mispredict_out), 32'(m_mis));
    if (m_mis) chk({tag, "_redirect"}, redirect_pc_out, m_red);
  endtask

  initial begin
    bit h, tk;
    logic [31:0] ptg, pc, tg;
    logic [4:0] opc;
    bit t, pt;

    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Reset state
    chk("rst_mispredict", 32'(mispredict_out), 32'd0);
    chk("rst_redirect", redirect_pc_out, 32'd0);
    look("rst_look", 32'h100);
    chk("rst_look_tgt_const", pred_target_out, 32'h104);
    look("wrap_look", 32'hFFFF_FFFC);
    chk("wrap_tgt_const", pred_target_out, 32'h0);

    // Branch allocate on taken miss
    upd("brn_alloc", 32'h100, BRN, 1, 32'h80, 0, 32'h0);
    chk("brn_alloc_red_const", redirect_pc_out, 32'h80);
    look("brn_after_alloc", 32'h100);
    chk("brn_alloc_taken_const", 32'(pred_taken_out), 32'd1);

    // Train down to strong-NT, then one taken, then saturate at 00
    upd("brn_nt1", 32'h100, BRN, 0, 32'h80, 1, 32'h80);
    chk("brn_nt1_red_const", redirect_pc_out, 32'h104);
    upd("brn_nt2", 32'h100, BRN, 0, 32'h80, 0, 32'h104);
    look("brn_after_nt2", 32'h100);
    upd("brn_t1", 32'h100, BRN, 1, 32'h80, 0, 32'h104);
    look("brn_after_t1", 32'h100);
    chk("brn_weak_nt_const", 32'(pred_taken_out), 32'd0);
    upd("brn_nt3", 32'h100, BRN, 0, 32'h80, 0, 32'h104);
    upd("brn_nt4", 32'h100, BRN, 0, 32'h80, 0, 32'h104);
    upd("brn_t2", 32'h100, BRN, 1, 32'h80, 0, 32'h104);
    look("brn_sat_low", 32'h100);

    // jalr target change
    upd("jalr_alloc", 32'h200, JALR, 1, 32'h300, 0, 32'h204);
    look("jalr_look1", 32'h200);
    upd("jalr_retarget", 32'h200, JALR, 1, 32'h340, 1, 32'h300);
    chk("jalr_red_const", redirect_pc_out, 32'h340);
    look("jalr_look2", 32'h200);
    chk("jalr_tgt_const", pred_target_out, 32'h340);

    // Aliasing on index 0
    upd("alias_140", 32'h140, BRN, 1, 32'h40, 0, 32'h144);
    look("alias_100", 32'h100);
    chk("alias_100_miss_const", 32'(pred_hit_out), 32'd0);
    look("alias_140", 32'h140);

    // Non control-flow opcode ignored
    upd("ignore_opc", 32'h140, 5'b01100, 0, 32'h0, 1, 32'h999);
    chk("ignore_mis_const", 32'(mispredict_out), 32'd0);
    look("ignore_look", 32'h140);

    // Same-cycle read/update to same index sees pre-update contents
    upd_valid_in = 1'b1; upd_pc_in = 32'h180; upd_opcode_6_to_2_in = JAL;
    upd_branch_taken_in = 1'b1; upd_target_in = 32'h500;
    upd_pred_taken_in = 1'b0; upd_pred_target_in = 32'h184;
    look("bypass_pre", 32'h180);
    @(posedge clk_in);
    model_update(32'h180, JAL, 1, 32'h500, 0, 32'h184);
    @(negedge clk_in);
    upd_valid_in = 1'b0;
    chk("bypass_mis", 32'(mispredict_out), 32'(m_mis));
    look("bypass_post", 32'h180);

    // Random traffic with randomized lookups each update cycle
    for (int n = 0; n < 300; n++) begin
      pc  = 32'h1000 + 32'($urandom_range(0, 63) << 2);
      case ($urandom_range(0, 5))
        0, 1, 2: opc = BRN;
        3:       opc = JAL;
        4:       opc = JALR;
        default: opc = 5'($urandom);
      endcase
      t  = (opc == JAL || opc == JALR) ? 1'b1 : 1'($urandom);
      tg = 32'h2000 + 32'($urandom_range(0, 3) << 4);
      model_pred(pc, h, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom);
        ptg = 32'h2000 + 32'($urandom_range(0, 3) << 4);
      end
      upd_valid_in = 1'b1; upd_pc_in = pc; upd_opcode_6_to_2_in = opc;
      upd_branch_taken_in = t; upd_target_in = tg;
      upd_pred_taken_in = pt; upd_pred_target_in = ptg;
      look("rnd_look", ($urandom_range(0, 1) == 1) ? pc
                        : 32'h1000 + 32'($urandom_range(0, 63) << 2));
      @(posedge clk_in);
      model_update(pc, opc, t, tg, pt, ptg);
      @(negedge clk_in);
      upd_valid_in = 1'b0;
      chk("rnd_mispredict", 32'(mispredict_out), 32'(m_mis));
      if (m_mis) chk("rnd_redirect", redirect_pc_out, m_red);
    end

`ifdef MSRV_32_BP_STATS_EN
    chk("stat_updates", stat_updates_out, 32'(m_nupd));
    chk("stat_mispredicts", stat_mispredicts_out, 32'(m_nmis));
`endif

    // Asynchronous reset mid-stream with mispredict high and an update in flight
    upd("pre_reset", 32'h100, BRN, 1, 32'h80, 0, 32'h104);
    chk("pre_reset_mis_const", 32'(mispredict_out), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    chk("reset_mis_drop", 32'(mispredict_out), 32'd0);
    chk("reset_redirect", redirect_pc_out, 32'd0);
`ifdef MSRV_32_BP_STATS_EN
    chk("reset_stat_upd", stat_updates_out, 32'd0);
    chk("reset_stat_mis", stat_mispredicts_out, 32'd0);
`endif
    upd_valid_in = 1'b1; upd_pc_in = 32'h200; upd_opcode_6_to_2_in = JAL;
    upd_branch_taken_in = 1'b1; upd_target_in = 32'h600;
    upd_pred_taken_in = 1'b0; upd_pred_target_in = 32'h0;
    @(posedge clk_in);
    @(negedge clk_in);
    upd_valid_in = 1'b0;
    rst_n_in = 1'b1;
    #1;
    look("post_reset_100", 32'h100);
    look("post_reset_200", 32'h200);
    look("post_reset_140", 32'h140);
    chk("post_reset_mis", 32'(mispredict_out), 32'd0);
    for (int n = 0; n < 8; n++) look("post_reset_rnd", 32'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv_32_branch_predictor.md
# msrv_32_branch_predictor

Direct-mapped branch predictor and target buffer for the msrv_32 core. It sits across the pipeline from the branch unit. Fetch receives a taken/target prediction for the current PC in the same cycle. The execute stage feeds the resolved `branch_taken` outcome back to train 2-bit saturating counters, and the block reports mispredictions as a registered redirect.

## Interface
- `ENTRIES`, default 16: table depth; power of two, 2..256; `IDX = log2(ENTRIES)`.
- `clk_in` input 1: core clock, all state on rising edge.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `pc_in` input 32: fetch PC to predict.
- `pred_hit_out` output 1: valid entry with matching tag for `pc_in` (combinational).
- `pred_taken_out` output 1: `pred_hit_out & counter[1]`.
- `pred_target_out` output 32: stored target when `pred_taken_out`, else `pc_in + 4`.
- `upd_valid_in` input 1: a resolved instruction is presented this cycle.
- `upd_pc_in` input 32: PC of resolved instruction.
- `upd_opcode_6_to_2_in` input 5: its opcode[6:2].
- `upd_branch_taken_in` input 1: actual outcome from the branch unit.
- `upd_target_in` input 32: actual taken target.
- `upd_pred_taken_in` input 1: prediction carried down the pipe for this instruction.
- `upd_pred_target_in` input 32: predicted target carried down the pipe.
- `mispredict_out` output 1: registered; high one cycle after a mispredicted update.
- `redirect_pc_out` output 32: registered; correct next PC, valid while `mispredict_out` is high.

## Operation
- Index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`. Each entry holds a valid bit, tag, 2-bit counter and 32-bit target.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Increment saturates at 11, decrement saturates at 00.
- Updates are accepted only when `upd_valid_in` is high and opcode ∈ {11000 branch, 11011 jal, 11001 jalr}. All other opcodes are ignored: no table write and no mispredict.
- Update, hit (valid and tag match): the counter steps toward the outcome. jal/jalr force 11. Target is overwritten with `upd_target_in` when taken.
- Update, miss:
  - Taken: allocate the entry (replace unconditionally), set valid, write tag and target. Counter = 10 for branch, 11 for jal/jalr.
  - Not taken: no write.
- Mispredict condition: `upd_pred_taken_in != upd_branch_taken_in`, or both taken and `upd_pred_target_in != upd_target_in`.
- `redirect_pc_out` = `upd_target_in` if taken, else `upd_pc_in + 4`. Address arithmetic is modulo 2^32.

## Timing
- Prediction is zero-latency combinational from table state.
- Table write and mispredict register take effect at the rising edge after the update. `mispredict_out` is a one-cycle pulse unless the next update also mispredicts.
- Same-cycle read and update to the same index: the prediction uses pre-update contents. There is no bypass.
- Back-to-back updates to the same entry apply sequentially, one per cycle.
- Reset, asynchronous, effective mid-operation:
  - All valid bits 0, counters 01, targets 0.
  - `mispredict_out` 0, `redirect_pc_out` 0.
  - Any in-flight update is discarded.
  - After release, `pred_hit_out` = 0, `pred_taken_out` = 0 and `pred_target_out` = `pc_in + 4` for every PC.

## Configuration
- `MSRV_32_BP_STATS_EN` defined:
  - Adds outputs `stat_updates_out[31:0]` (counts accepted control-flow updates) and `stat_mispredicts_out[31:0]` (counts mispredicts).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package `msrv_32_pkg` holds:
  - opcode constants (BRN = 11000, JAL = 11011, JALR = 11001);
  - counter encodings (SNT, WNT, WT, ST).
- Sub-module `msrv_32_sat_counter`: 2-bit saturating next-state logic. Inputs: current state, taken, force_strong. Output: next state.

## Test plan
- Post-reset lookup of `pc_in` = 0x100 -> `pred_hit_out` = 0, `pred_taken_out` = 0, `pred_target_out` = 0x104.
- Update branch at 0x100, taken, target 0x80, pred NT -> next cycle `mispredict_out` = 1 and `redirect_pc_out` = 0x80. A lookup of 0x100 then gives hit, taken, target 0x80 (counter 10).
- Same branch resolved not-taken twice -> counter 10→01→00; prediction NT. Then taken once -> 01, still NT; saturation holds at 00 on further NT.
- jalr at 0x200: first taken to 0x300, then predicted taken and resolved to 0x340 -> mispredict with redirect 0x340; stored target becomes 0x340.
- Aliasing with ENTRIES = 16: 0x100 allocated, then taken update at 0x140 (same index, different tag) -> 0x100 now misses and 0x140 hits. An update with opcode 01100 and `upd_valid_in` = 1 -> no change and no mispredict.
- Assert `rst_n_in` low mid-stream with `mispredict_out` high -> `mispredict_out` drops immediately and all entries read as miss; with `MSRV_32_BP_STATS_EN`, both statistics counters read 0.
